// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round count and the linear-layer helpers
// (xtime, mix_column, shift_rows) used by the round datapath.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [0:127] block_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] mix_column(input logic [0:31] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[0:7];
    a1 = col[8:15];
    a2 = col[16:23];
    a3 = col[24:31];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte 4c+r holds row r of column c; row r takes its byte from column (c+r) mod 4.
  function automatic block_t shift_rows(input block_t b);
    block_t res;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        res[8*(4*c+row) +: 8] = b[8*(4*((c+row)%4)+row) +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [0:127] st,
  input  logic [0:127] rk,
  input  logic         last_round,
  output logic [0:127] nxt
);

  logic [0:127] sub;
  logic [0:127] shifted;
  logic [0:127] mixed;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (st[8*i +: 8]),
      .dout (sub[8*i +: 8])
    );
  end

  assign shifted = shift_rows(sub);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
  end

  // The final round omits MixColumns.
  assign nxt = (last_round ? shifted : mixed) ^ rk;

endmodule

// File: rtl/aes_sbox.sv
// AES S-box cell: multiplicative inverse in GF(2^8) (poly 0x11b) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 is the inverse for nonzero a and maps 0 to 0, as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  assign inv  = gf_inv(din);
  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryptor, one round per clock with valid/ready on both sides.
// Define AES_ENGINE_ZEROIZE_EN to clear the state and ciphertext on each output handshake.
module aes128_round_engine
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
  parameter int CNT_W      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  input  logic [0:127] round_key0,
  input  logic [0:127] round_key1,
  input  logic [0:127] round_key2,
  input  logic [0:127] round_key3,
  input  logic [0:127] round_key4,
  input  logic [0:127] round_key5,
  input  logic [0:127] round_key6,
  input  logic [0:127] round_key7,
  input  logic [0:127] round_key8,
  input  logic [0:127] round_key9,
  input  logic [0:127] round_key10,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ciphertext
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [0:127]       st_p0;
  logic [0:127]       rk_sel;
  logic [0:127]       round_nxt;
  logic               last_round;

  assign last_round = (cnt == CNT_W'(NUM_ROUNDS));
  assign in_ready   = !rst && ((state == IDLE) || (state == DONE && out_ready));

  always_comb begin
    rk_sel = round_key0;
    case (cnt)
      CNT_W'(1):  rk_sel = round_key1;
      CNT_W'(2):  rk_sel = round_key2;
      CNT_W'(3):  rk_sel = round_key3;
      CNT_W'(4):  rk_sel = round_key4;
      CNT_W'(5):  rk_sel = round_key5;
      CNT_W'(6):  rk_sel = round_key6;
      CNT_W'(7):  rk_sel = round_key7;
      CNT_W'(8):  rk_sel = round_key8;
      CNT_W'(9):  rk_sel = round_key9;
      CNT_W'(10): rk_sel = round_key10;
      default:    rk_sel = round_key0;
    endcase
  end

  aes_round_comb u_round (
    .st         (st_p0),
    .rk         (rk_sel),
    .last_round (last_round),
    .nxt        (round_nxt)
  );

  // Round state register, counter and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      st_p0      <= '0;
      ciphertext <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st_p0 <= plaintext ^ round_key0;
            cnt   <= CNT_W'(1);
            state <= ROUND;
          end
        end
        ROUND: begin
          st_p0 <= round_nxt;
          if (last_round) begin
            ciphertext <= round_nxt;
            out_valid  <= 1'b1;
            cnt        <= '0;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef AES_ENGINE_ZEROIZE_EN
            st_p0      <= '0;
            ciphertext <= '0;
`endif
            if (in_valid) begin
              st_p0 <= plaintext ^ round_key0;
              cnt   <= CNT_W'(1);
              state <= ROUND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
